ft60x_bus_model: RTL and testbench

Parametrised, cycle-accurate model of the FIFO side of an FT600/FT601 in 245 synchronous-FIFO mode. It replaces the static `ftdi_rxf_n`/`ftdi_txe_n` stimulus in stream-top benches. The model holds a host→FPGA RX FIFO, filled through a push port, and an FPGA→host TX FIFO, drained through a pop port. It drives the flags and the bidirectional bus as the chip does, for 16-bit (FT600) or 32-bit (FT601) builds. Sticky flags record protocol violations by the FPGA-side controller.

---
 rtl/ft60x_bus_model.sv | 210 +++++++++++++++++++++
 tb/tb_ft60x_bus_model.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft60x_bus_model.sv
// ---------------------------------------------------------------------------
// ft60x_bus_model
//
// Cycle-accurate model of the FIFO side of an FT600 (16-bit) / FT601 (32-bit)
// in 245 synchronous-FIFO mode. It stands in for the chip in stream-top
// benches.
//
// The host side fills an RX FIFO (host->FPGA) through a push handshake and
// drains a TX FIFO (FPGA->host) through a pop handshake. The FPGA-side
// controller reads and writes through the flags, the strobes and the
// bidirectional data/byte-enable bus, as it would with the real chip.
//
// Ports
//   ftdi_clk, rst_n          clock, asynchronous active-low reset
//   ftdi_resetn              chip reset from controller (sync flush, low)
//   ftdi_oe_n/rd_n/wr_n      controller strobes
//   ftdi_rxf_n, ftdi_txe_n   registered RX-available / TX-space flags
//   ftdi_data, ftdi_be       bidirectional bus, driven with the RX head
//                            while output enable is registered
//   tx_stall                 host not reading: forces ftdi_txe_n high
//   host_push_*              RX enqueue handshake (data + byte enables)
//   host_pop_*               TX dequeue handshake (head shown combinationally)
//   rx_level, tx_level       FIFO occupancy
//   err_underrun/overrun/contention  sticky protocol-violation flags,
//                            cleared only by rst_n
// ---------------------------------------------------------------------------
module ft60x_bus_model #(
  parameter int DATA_W   = 16,
  parameter int BE_W     = DATA_W / 8,
  parameter int RX_DEPTH = 1024,
  parameter int TX_DEPTH = 1024
) (
  input  logic                            ftdi_clk,
  input  logic                            rst_n,
  input  logic                            ftdi_resetn,
  input  logic                            ftdi_oe_n,
  input  logic                            ftdi_rd_n,
  input  logic                            ftdi_wr_n,
  output logic                            ftdi_rxf_n,
  output logic                            ftdi_txe_n,
  inout  wire  [DATA_W-1:0]               ftdi_data,
  inout  wire  [BE_W-1:0]                 ftdi_be,
  input  logic                            tx_stall,
  input  logic                            host_push_valid,
  output logic                            host_push_ready,
  input  logic [DATA_W-1:0]               host_push_data,
  input  logic [BE_W-1:0]                 host_push_be,
  output logic                            host_pop_valid,
  input  logic                            host_pop_ready,
  output logic [DATA_W-1:0]               host_pop_data,
  output logic [BE_W-1:0]                 host_pop_be,
  output logic [$clog2(RX_DEPTH+1)-1:0]   rx_level,
  output logic [$clog2(TX_DEPTH+1)-1:0]   tx_level,
  output logic                            err_underrun,
  output logic                            err_overrun,
  output logic                            err_contention
);

  localparam int RX_AW  = $clog2(RX_DEPTH);
  localparam int TX_AW  = $clog2(TX_DEPTH);
  localparam int RX_LW  = $clog2(RX_DEPTH + 1);
  localparam int TX_LW  = $clog2(TX_DEPTH + 1);
  localparam int WORD_W = DATA_W + BE_W;

  localparam logic [RX_LW-1:0] RX_FULL  = RX_LW'(RX_DEPTH);
  localparam logic [TX_LW-1:0] TX_FULL  = TX_LW'(TX_DEPTH);
  localparam logic [RX_LW-1:0] RX_EMPTY = {RX_LW{1'b0}};
  localparam logic [TX_LW-1:0] TX_EMPTY = {TX_LW{1'b0}};

  // Storage: each entry is {data, byte enables}
  logic [WORD_W-1:0] rx_mem_q [RX_DEPTH];
  logic [WORD_W-1:0] tx_mem_q [TX_DEPTH];

  logic [RX_AW-1:0]  rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [TX_AW-1:0]  tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [RX_LW-1:0]  rx_level_q, rx_level_d;
  logic [TX_LW-1:0]  tx_level_q, tx_level_d;
  logic              rxf_n_q, rxf_n_d;
  logic              txe_n_q, txe_n_d;
  logic              oe_q, oe_d;
  logic [WORD_W-1:0] bus_q, bus_d;
  logic              err_underrun_q, err_underrun_d;
  logic              err_overrun_q, err_overrun_d;
  logic              err_contention_q, err_contention_d;

  logic              rd_fire_s, wr_fire_s, push_fire_s, pop_fire_s;
  logic [WORD_W-1:0] push_word_s, wire_word_s, tx_head_s;

  assign push_word_s = {host_push_data, host_push_be};
  assign wire_word_s = {ftdi_data, ftdi_be};
  assign tx_head_s   = tx_mem_q[tx_rd_ptr_q];

  // Transfers qualify on the registered flags the controller actually sees.
  assign rd_fire_s   = ~ftdi_rd_n & ~ftdi_oe_n & ~rxf_n_q;
  assign wr_fire_s   = ~ftdi_wr_n & ~txe_n_q;
  assign push_fire_s = host_push_valid & host_push_ready;
  assign pop_fire_s  = host_pop_valid & host_pop_ready;

  // rst_n gates ready so it reads 0 throughout asynchronous reset.
  assign host_push_ready = rst_n & ftdi_resetn & (rx_level_q != RX_FULL);
  assign host_pop_valid  = (tx_level_q != TX_EMPTY);
  assign host_pop_data   = tx_head_s[WORD_W-1:BE_W];
  assign host_pop_be     = tx_head_s[BE_W-1:0];

  assign ftdi_rxf_n     = rxf_n_q;
  assign ftdi_txe_n     = txe_n_q;
  assign rx_level       = rx_level_q;
  assign tx_level       = tx_level_q;
  assign err_underrun   = err_underrun_q;
  assign err_overrun    = err_overrun_q;
  assign err_contention = err_contention_q;

  assign ftdi_data = oe_q ? bus_q[WORD_W-1:BE_W] : {DATA_W{1'bz}};
  assign ftdi_be   = oe_q ? bus_q[BE_W-1:0]      : {BE_W{1'bz}};

  // Next-state: pointers, levels, flags, bus head and sticky errors
  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    rx_level_d  = rx_level_q;
    tx_level_d  = tx_level_q;
    bus_d       = bus_q;

    if (!ftdi_resetn) begin
      // Chip reset flushes both FIFOs at this edge.
      rx_wr_ptr_d = {RX_AW{1'b0}};
      rx_rd_ptr_d = {RX_AW{1'b0}};
      tx_wr_ptr_d = {TX_AW{1'b0}};
      tx_rd_ptr_d = {TX_AW{1'b0}};
      rx_level_d  = RX_EMPTY;
      tx_level_d  = TX_EMPTY;
    end else begin
      rx_wr_ptr_d = rx_wr_ptr_q + RX_AW'(push_fire_s);
      rx_rd_ptr_d = rx_rd_ptr_q + RX_AW'(rd_fire_s);
      tx_wr_ptr_d = tx_wr_ptr_q + TX_AW'(wr_fire_s);
      tx_rd_ptr_d = tx_rd_ptr_q + TX_AW'(pop_fire_s);
      rx_level_d  = rx_level_q + RX_LW'(push_fire_s) - RX_LW'(rd_fire_s);
      tx_level_d  = tx_level_q + TX_LW'(wr_fire_s) - TX_LW'(pop_fire_s);
    end

    // Bus register tracks the next RX head; it holds the last head when
    // the FIFO drains. If every stored word leaves (or none was stored),
    // the new head can only be the word being pushed this edge, which is
    // not yet in memory, so it is bypassed.
    if (ftdi_resetn && (rx_level_d != RX_EMPTY)) begin
      if (rx_level_q == RX_LW'(rd_fire_s)) begin
        bus_d = push_word_s;
      end else begin
        bus_d = rx_mem_q[rx_rd_ptr_d];
      end
    end else begin
      bus_d = bus_q;
    end

    rxf_n_d = (rx_level_d == RX_EMPTY);
    txe_n_d = (tx_level_d == TX_FULL) | tx_stall | ~ftdi_resetn;
    oe_d    = ~ftdi_oe_n & ftdi_resetn;

    err_underrun_d   = err_underrun_q | (~ftdi_rd_n & ~ftdi_oe_n & rxf_n_q);
    err_overrun_d    = err_overrun_q  | (~ftdi_wr_n & txe_n_q);
    err_contention_d = err_contention_q | (~ftdi_wr_n & oe_q) |
                       (~ftdi_oe_n & ~ftdi_wr_n);
  end

  // FIFO storage writes (data array, not reset)
  always_ff @(posedge ftdi_clk) begin
    if (push_fire_s) begin
      rx_mem_q[rx_wr_ptr_q] <= push_word_s;
    end
    if (wr_fire_s) begin
      tx_mem_q[tx_wr_ptr_q] <= wire_word_s;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr_q      <= {RX_AW{1'b0}};
      rx_rd_ptr_q      <= {RX_AW{1'b0}};
      tx_wr_ptr_q      <= {TX_AW{1'b0}};
      tx_rd_ptr_q      <= {TX_AW{1'b0}};
      rx_level_q       <= RX_EMPTY;
      tx_level_q       <= TX_EMPTY;
      rxf_n_q          <= 1'b1;
      txe_n_q          <= 1'b1;
      oe_q             <= 1'b0;
      bus_q            <= {WORD_W{1'b0}};
      err_underrun_q   <= 1'b0;
      err_overrun_q    <= 1'b0;
      err_contention_q <= 1'b0;
    end else begin
      rx_wr_ptr_q      <= rx_wr_ptr_d;
      rx_rd_ptr_q      <= rx_rd_ptr_d;
      tx_wr_ptr_q      <= tx_wr_ptr_d;
      tx_rd_ptr_q      <= tx_rd_ptr_d;
      rx_level_q       <= rx_level_d;
      tx_level_q       <= tx_level_d;
      rxf_n_q          <= rxf_n_d;
      txe_n_q          <= txe_n_d;
      oe_q             <= oe_d;
      bus_q            <= bus_d;
      err_underrun_q   <= err_underrun_d;
      err_overrun_q    <= err_overrun_d;
      err_contention_q <= err_contention_d;
    end
  end

endmodule

// File: tb/tb_ft60x_bus_model.sv
// ---------------------------------------------------------------------------
// Bench for ft60x_bus_model, 32-bit build with 8-word FIFOs.
// A queue-based model tracks the FIFOs, flags and sticky errors; it is
// compared against the DUT on every falling edge, and directed sequences add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_ft60x_bus_model;

  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int RXD = 8;
  localparam int TXD = 8;

  typedef logic [DW+BW-1:0] word_t;

  logic          ftdi_clk = 1'b0;
  logic          rst_n, ftdi_resetn, ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, tx_stall;
  logic          ftdi_rxf_n, ftdi_txe_n;
  wire  [DW-1:0] ftdi_data;
  wire  [BW-1:0] ftdi_be;
  logic          host_push_valid, host_push_ready;
  logic [DW-1:0] host_push_data;
  logic [BW-1:0] host_push_be;
  logic          host_pop_valid, host_pop_ready;
  logic [DW-1:0] host_pop_data;
  logic [BW-1:0] host_pop_be;
  logic [3:0]    rx_level, tx_level;
  logic          err_underrun, err_overrun, err_contention;

  logic          tb_drv;
  logic [DW-1:0] tb_data;
  logic [BW-1:0] tb_be;

  int checks   = 0;
  int failures = 0;

  assign ftdi_data = tb_drv ? tb_data : {DW{1'bz}};
  assign ftdi_be   = tb_drv ? tb_be   : {BW{1'bz}};

  always #5 ftdi_clk = ~ftdi_clk;

  ft60x_bus_model #(.DATA_W(DW), .BE_W(BW), .RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
    .ftdi_clk(ftdi_clk), .rst_n(rst_n), .ftdi_resetn(ftdi_resetn),
    .ftdi_oe_n(ftdi_oe_n), .ftdi_rd_n(ftdi_rd_n), .ftdi_wr_n(ftdi_wr_n),
    .ftdi_rxf_n(ftdi_rxf_n), .ftdi_txe_n(ftdi_txe_n),
    .ftdi_data(ftdi_data), .ftdi_be(ftdi_be), .tx_stall(tx_stall),
    .host_push_valid(host_push_valid), .host_push_ready(host_push_ready),
    .host_push_data(host_push_data), .host_push_be(host_push_be),
    .host_pop_valid(host_pop_valid), .host_pop_ready(host_pop_ready),
    .host_pop_data(host_pop_data), .host_pop_be(host_pop_be),
    .rx_level(rx_level), .tx_level(tx_level),
    .err_underrun(err_underrun), .err_overrun(err_overrun),
    .err_contention(err_contention)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  word_t rxq[$];
  word_t txq[$];
  logic  m_rxf_n, m_txe_n, m_oe, m_eu, m_eo, m_ec;
  word_t m_bus;

  always @(posedge ftdi_clk or negedge rst_n) begin : model
    bit    rd_e, wr_e, psh_e, pp_e;
    word_t wv;
    if (!rst_n) begin
      rxq.delete();
      txq.delete();
      m_rxf_n <= 1'b1; m_txe_n <= 1'b1; m_oe <= 1'b0; m_bus <= '0;
      m_eu <= 1'b0; m_eo <= 1'b0; m_ec <= 1'b0;
    end else begin
      rd_e  = !ftdi_rd_n && !ftdi_oe_n && !m_rxf_n;
      wr_e  = !ftdi_wr_n && !m_txe_n;
      psh_e = host_push_valid && ftdi_resetn && (rxq.size() < RXD);
      pp_e  = (txq.size() != 0) && host_pop_ready;
      wv    = tb_drv ? {tb_data, tb_be} : (m_oe ? m_bus : '0);
      if (!ftdi_rd_n && !ftdi_oe_n && m_rxf_n) m_eu <= 1'b1;
      if (!ftdi_wr_n && m_txe_n) m_eo <= 1'b1;
      if ((!ftdi_wr_n && m_oe) || (!ftdi_oe_n && !ftdi_wr_n)) m_ec <= 1'b1;
      if (!ftdi_resetn) begin
        rxq.delete();
        txq.delete();
      end else begin
        if (rd_e)  void'(rxq.pop_front());
        if (psh_e) rxq.push_back({host_push_data, host_push_be});
        if (pp_e)  void'(txq.pop_front());
        if (wr_e)  txq.push_back(wv);
      end
      m_rxf_n <= (rxq.size() == 0);
      m_txe_n <= (txq.size() == TXD) || tx_stall || !ftdi_resetn;
      m_oe    <= !ftdi_oe_n && ftdi_resetn;
      if (rxq.size() != 0) m_bus <= rxq[0];
    end
  end

  // ---------------- every-cycle comparison ----------------
  always @(negedge ftdi_clk) begin
    chk("rxf_n", ftdi_rxf_n, m_rxf_n);
    chk("txe_n", ftdi_txe_n, m_txe_n);
    chk("rx_level", rx_level, rxq.size());
    chk("tx_level", tx_level, txq.size());
    chk("push_ready", host_push_ready, rst_n && ftdi_resetn && (rxq.size() < RXD));
    chk("pop_valid", host_pop_valid, txq.size() != 0);
    if (txq.size() != 0) chk("pop_word", {host_pop_data, host_pop_be}, txq[0]);
    chk("err_underrun", err_underrun, m_eu);
    chk("err_overrun", err_overrun, m_eo);
    chk("err_contention", err_contention, m_ec);
    if (m_oe && !tb_drv) chk("bus_drive", {ftdi_data, ftdi_be}, m_bus);
    if (!m_oe && tb_drv) chk("bus_release", {ftdi_data, ftdi_be}, {tb_data, tb_be});
  end

  task automatic tick();
    @(posedge ftdi_clk);
    #2;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; ftdi_resetn = 1'b1; ftdi_oe_n = 1'b1; ftdi_rd_n = 1'b1;
    ftdi_wr_n = 1'b1; tx_stall = 1'b0; host_push_valid = 1'b0;
    host_push_data = 32'h0; host_push_be = 4'hF; host_pop_ready = 1'b0;
    tb_drv = 1'b0; tb_data = 32'h0; tb_be = 4'h0;
    repeat (2) tick();
    chk("rst_rxf_n", ftdi_rxf_n, 1'b1);
    chk("rst_txe_n", ftdi_txe_n, 1'b1);
    chk("rst_push_ready", host_push_ready, 1'b0);
    chk("rst_pop_valid", host_pop_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("txe_after_release", ftdi_txe_n, 1'b0);

    // three pushes, then a three-word read burst
    host_push_valid = 1'b1; host_push_data = 32'h1111;
    tick();
    chk("rxf_fall_first_push", ftdi_rxf_n, 1'b0);
    chk("rx_level_1", rx_level, 4'd1);
    host_push_data = 32'h2222; tick();
    host_push_data = 32'h3333; tick();
    host_push_valid = 1'b0;
    ftdi_oe_n = 1'b0; tick();
    chk("bus_1111", ftdi_data, 32'h1111);
    ftdi_rd_n = 1'b0; tick();
    chk("bus_2222", ftdi_data, 32'h2222);
    tick();
    chk("bus_3333", ftdi_data, 32'h3333);
    tick();
    chk("rxf_n_third_pop", ftdi_rxf_n, 1'b1);
    chk("bus_hold_3333", ftdi_data, 32'h3333);
    ftdi_rd_n = 1'b1; ftdi_oe_n = 1'b1; tick();
    chk("no_err_after_burst", {err_underrun, err_overrun, err_contention}, 3'b000);

    // fill TX, overrun, pop one, drain
    tb_drv = 1'b1; ftdi_wr_n = 1'b0;
    for (int i = 0; i < TXD; i++) begin
      tb_data = (i == 0) ? 32'hCAFEF00D : 32'h10000000 + i;
      tb_be   = (i == 0) ? 4'hF : 4'(i);
      tick();
    end
    chk("tx_full_level", tx_level, 4'd8);
    chk("tx_full_txe_n", ftdi_txe_n, 1'b1);
    tb_data = 32'hBAD0BAD0; tick();
    chk("overrun_flag", err_overrun, 1'b1);
    chk("overrun_level", tx_level, 4'd8);
    ftdi_wr_n = 1'b1; tb_drv = 1'b0;
    chk("pop_head_data", host_pop_data, 32'hCAFEF00D);
    chk("pop_head_be", host_pop_be, 4'hF);
    host_pop_ready = 1'b1; tick();
    host_pop_ready = 1'b0;
    chk("txe_after_pop", ftdi_txe_n, 1'b0);
    chk("tx_level_7", tx_level, 4'd7);
    host_pop_ready = 1'b1; repeat (7) tick();
    host_pop_ready = 1'b0;
    chk("tx_drained", tx_level, 4'd0);

    // stall
    tx_stall = 1'b1; tick();
    chk("stall_txe", ftdi_txe_n, 1'b1);
    tx_stall = 1'b0; tick();
    chk("unstall_txe", ftdi_txe_n, 1'b0);

    // 32-bit word with partial byte enables
    host_push_valid = 1'b1; host_push_data = 32'hDEADBEEF; host_push_be = 4'b0111;
    tick();
    host_push_valid = 1'b0; host_push_be = 4'hF;
    ftdi_oe_n = 1'b0; tick();
    chk("bus_deadbeef", ftdi_data, 32'hDEADBEEF);
    chk("bus_be_0111", ftdi_be, 4'b0111);
    ftdi_rd_n = 1'b0; tick();
    ftdi_rd_n = 1'b1; ftdi_oe_n = 1'b1;
    chk("rx_empty_after_dead", rx_level, 4'd0);

    // simultaneous push and pop at level 5
    host_push_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_push_data = 32'hA0 + i;
      tick();
    end
    host_push_valid = 1'b0;
    ftdi_oe_n = 1'b0; tick();
    ftdi_rd_n = 1'b0; host_push_valid = 1'b1; host_push_data = 32'hA5; tick();
    host_push_valid = 1'b0;
    chk("level_stays_5", rx_level, 4'd5);
    chk("bus_a1", ftdi_data, 32'hA1);
    repeat (5) tick();
    chk("bus_hold_a5", ftdi_data, 32'hA5);
    chk("no_underrun_yet", err_underrun, 1'b0);
    tick();
    chk("underrun_flag", err_underrun, 1'b1);
    ftdi_rd_n = 1'b1;

    // contention: oe held low, write pulse captures the driven head
    ftdi_wr_n = 1'b0; tick();
    ftdi_wr_n = 1'b1;
    chk("contention_flag", err_contention, 1'b1);
    chk("contention_word", host_pop_data, 32'hA5);
    ftdi_oe_n = 1'b1;

    // chip reset with both FIFOs non-empty
    host_push_valid = 1'b1; host_push_data = 32'h55; tick(); tick();
    host_push_valid = 1'b0;
    chk("pre_flush_rx", rx_level, 4'd2);
    chk("pre_flush_tx", tx_level, 4'd1);
    ftdi_resetn = 1'b0; tick();
    chk("flush_levels", {rx_level, tx_level}, 8'h00);
    chk("flush_flags", {ftdi_rxf_n, ftdi_txe_n}, 2'b11);
    chk("flush_keeps_err", {err_underrun, err_overrun, err_contention}, 3'b111);
    ftdi_resetn = 1'b1; tick();
    chk("txe_after_flush", ftdi_txe_n, 1'b0);

    // asynchronous reset in the middle of a read burst
    host_push_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_push_data = 32'hB1 + i;
      tick();
    end
    host_push_valid = 1'b0;
    ftdi_oe_n = 1'b0; tick();
    ftdi_rd_n = 1'b0; tick();
    chk("burst_bus_b2", ftdi_data, 32'hB2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_flags", {ftdi_rxf_n, ftdi_txe_n}, 2'b11);
    chk("async_levels", {rx_level, tx_level}, 8'h00);
    chk("async_err_clear", {err_underrun, err_overrun, err_contention}, 3'b000);
    tb_drv = 1'b1; tb_data = 32'h0; tb_be = 4'h0;
    #1;
    chk("async_bus_released", {ftdi_data, ftdi_be}, 36'h0);
    ftdi_rd_n = 1'b1; ftdi_oe_n = 1'b1;
    tick();
    tb_drv = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_release_txe", ftdi_txe_n, 1'b0);
    chk("post_release_levels", {rx_level, tx_level}, 8'h00);
    chk("post_release_rxf", ftdi_rxf_n, 1'b1);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
